demux4_tdm: RTL and testbench



---
 rtl/demux4_pkg.sv | 18 +
 rtl/demux4_slot_ctr.sv | 40 ++++
 rtl/demux4_tdm.sv | 136 +++++++++++++
 tb/tb_demux4_tdm.sv | 136 +++++++++++++
 4 files changed

// File: rtl/demux4_pkg.sv
// Shared types and constants for the demux4_tdm receive path.
// Optional parity checking is enabled by DEMUX4_PARITY_EN (see demux4_tdm).
package demux4_pkg;

  localparam int SLOT_W = 2;
  localparam int NUM_CH = 4;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Returns 1 when data plus its parity bit does not have even parity.
  function automatic logic even_par_bad(input logic [31:0] data, input logic par);
    return (^data) ^ par;
  endfunction

endpackage

// File: rtl/demux4_slot_ctr.sv
// Two-bit wrapping slot counter with clear and load-to-1 (frame start).
module demux4_slot_ctr
  import demux4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              load1_i,
  input  logic              inc_i,
  output logic [SLOT_W-1:0] slot_o
);

  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;

  // Clear beats load, load beats increment.
  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = '0;
    end else if (load1_i) begin
      slot_d = SLOT_W'(1);
    end else if (inc_i) begin
      slot_d = slot_q + SLOT_W'(1);
    end else begin
      slot_d = slot_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/demux4_tdm.sv
// Time-division 1-to-4 demultiplexer: frame-sync alignment, per-channel registers.
// Define DEMUX4_PARITY_EN to reject words failing even parity over in_data_i.
module demux4_tdm
  import demux4_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic              in_sync_i,
  input  logic [DW-1:0]     in_data_i,
  input  logic              in_par_i,
  output logic [4*DW-1:0]   out_data_o,
  output logic [NUM_CH-1:0] out_upd_o,
  output logic              frame_valid_o,
  output logic [SLOT_W-1:0] slot_o,
  output logic              locked_o,
  output logic              err_o
);

  state_e              state_q, state_d;
  logic                frame_ok_q, frame_ok_d;
  logic [4*DW-1:0]     data_q, data_d;
  logic [NUM_CH-1:0]   upd_q, upd_d;
  logic                fv_q, fv_d;
  logic                err_q, err_d;
  logic                clr_s, load1_s, inc_s;
  logic [SLOT_W-1:0]   slot_s;
  logic                par_bad_s;

`ifdef DEMUX4_PARITY_EN
  assign par_bad_s = even_par_bad(32'(in_data_i), in_par_i);
`else
  logic unused_par_s;
  assign unused_par_s = in_par_i;
  assign par_bad_s    = 1'b0;
`endif

  demux4_slot_ctr u_slot_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr_s),
    .load1_i (load1_s),
    .inc_i   (inc_s),
    .slot_o  (slot_s)
  );

  // Parity is checked before any sync handling so a corrupt sync never locks.
  always_comb begin
    state_d    = state_q;
    frame_ok_d = frame_ok_q;
    data_d     = data_q;
    upd_d      = '0;
    fv_d       = 1'b0;
    err_d      = 1'b0;
    clr_s      = 1'b0;
    load1_s    = 1'b0;
    inc_s      = 1'b0;
    if (!in_valid_i) begin
      state_d = state_q;
    end else if (par_bad_s) begin
      err_d   = 1'b1;
      state_d = HUNT;
      clr_s   = 1'b1;
    end else begin
      case (state_q)
        HUNT: begin
          if (in_sync_i) begin
            data_d[0 +: DW] = in_data_i;
            upd_d[0]        = 1'b1;
            load1_s         = 1'b1;
            frame_ok_d      = 1'b1;
            state_d         = RUN;
          end else begin
            state_d = HUNT;
          end
        end
        RUN: begin
          if (in_sync_i) begin
            // A sync off slot 0 aborts the partial frame; the new one starts clean.
            err_d           = (slot_s != SLOT_W'(0));
            data_d[0 +: DW] = in_data_i;
            upd_d[0]        = 1'b1;
            load1_s         = 1'b1;
            frame_ok_d      = 1'b1;
          end else if (slot_s == SLOT_W'(0)) begin
            err_d   = 1'b1;
            state_d = HUNT;
            clr_s   = 1'b1;
          end else begin
            data_d[slot_s*DW +: DW] = in_data_i;
            upd_d[slot_s]           = 1'b1;
            inc_s                   = 1'b1;
            if (slot_s == SLOT_W'(3)) begin
              fv_d       = frame_ok_q;
              frame_ok_d = 1'b1;
            end else begin
              fv_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          clr_s   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      frame_ok_q <= 1'b0;
      data_q     <= '0;
      upd_q      <= '0;
      fv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_ok_q <= frame_ok_d;
      data_q     <= data_d;
      upd_q      <= upd_d;
      fv_q       <= fv_d;
      err_q      <= err_d;
    end
  end

  assign out_data_o    = data_q;
  assign out_upd_o     = upd_q;
  assign frame_valid_o = fv_q;
  assign err_o         = err_q;
  assign slot_o        = slot_s;
  assign locked_o      = (state_q == RUN);

endmodule

// File: tb/tb_demux4_tdm.sv
// Directed self-checking bench for demux4_tdm (DW=4).
module tb_demux4_tdm;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_sync;
  logic [3:0]  in_data;
  logic        in_par;
  logic [15:0] out_data;
  logic [3:0]  out_upd;
  logic        frame_valid;
  logic [1:0]  slot;
  logic        locked;
  logic        err;

  int checks_cnt = 0;
  int errors_cnt = 0;

  demux4_tdm #(.DW(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid),
    .in_sync_i     (in_sync),
    .in_data_i     (in_data),
    .in_par_i      (in_par),
    .out_data_o    (out_data),
    .out_upd_o     (out_upd),
    .frame_valid_o (frame_valid),
    .slot_o        (slot),
    .locked_o      (locked),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of input (parity computed good unless bad_par) and sample after the edge.
  task automatic step(input logic v, input logic s, input logic [3:0] d, input logic bad_par);
    @(negedge clk);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    in_par   = (^d) ^ bad_par;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_data, input logic [3:0] e_upd,
                           input logic e_fv, input logic [1:0] e_slot, input logic e_lock,
                           input logic e_err);
    check({tag, ".data"}, 32'(out_data), 32'(e_data));
    check({tag, ".upd"},  32'(out_upd),  32'(e_upd));
    check({tag, ".fv"},   32'(frame_valid), 32'(e_fv));
    check({tag, ".slot"}, 32'(slot),     32'(e_slot));
    check({tag, ".lock"}, 32'(locked),   32'(e_lock));
    check({tag, ".err"},  32'(err),      32'(e_err));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sync = 1'b0; in_data = 4'h0; in_par = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 16'h0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsynced words are dropped
    step(1'b1, 1'b0, 4'd7, 1'b0); check_all("hunt7", 16'h0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd8, 1'b0); check_all("hunt8", 16'h0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

    // First frame 3,5,9,12
    step(1'b1, 1'b1, 4'd3,  1'b0); check_all("f1s0", 16'h0003, 4'b0001, 1'b0, 2'd1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd5,  1'b0); check_all("f1s1", 16'h0053, 4'b0010, 1'b0, 2'd2, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd9,  1'b0); check_all("f1s2", 16'h0953, 4'b0100, 1'b0, 2'd3, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd12, 1'b0); check_all("f1s3", 16'hC953, 4'b1000, 1'b1, 2'd0, 1'b1, 1'b0);

    // Back-to-back frame 1,2,4,8
    step(1'b1, 1'b1, 4'd1, 1'b0); check_all("f2s0", 16'hC951, 4'b0001, 1'b0, 2'd1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd2, 1'b0); check_all("f2s1", 16'hC921, 4'b0010, 1'b0, 2'd2, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd4, 1'b0); check_all("f2s2", 16'hC421, 4'b0100, 1'b0, 2'd3, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd8, 1'b0); check_all("f2s3", 16'h8421, 4'b1000, 1'b1, 2'd0, 1'b1, 1'b0);

    // Misaligned sync at slot 2, then the new frame completes
    step(1'b1, 1'b1, 4'd1, 1'b0); check_all("m0",   16'h8421, 4'b0001, 1'b0, 2'd1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd2, 1'b0); check_all("m1",   16'h8421, 4'b0010, 1'b0, 2'd2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'd6, 1'b0); check_all("mis",  16'h8426, 4'b0001, 1'b0, 2'd1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 4'd7, 1'b0); check_all("n1",   16'h8476, 4'b0010, 1'b0, 2'd2, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd9, 1'b0); check_all("n2",   16'h8976, 4'b0100, 1'b0, 2'd3, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'hA, 1'b0); check_all("n3",   16'hA976, 4'b1000, 1'b1, 2'd0, 1'b1, 1'b0);

    // Missing sync at slot 0
    step(1'b1, 1'b0, 4'hB, 1'b0); check_all("nosync", 16'hA976, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);

    // Frame with idle gaps between words
    step(1'b1, 1'b1, 4'd1, 1'b0); check_all("g0",  16'hA971, 4'b0001, 1'b0, 2'd1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'hF, 1'b0); check_all("gi0", 16'hA971, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd2, 1'b0); check_all("g1",  16'hA921, 4'b0010, 1'b0, 2'd2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'hF, 1'b0); check_all("gi1", 16'hA921, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd3, 1'b0); check_all("g2",  16'hA321, 4'b0100, 1'b0, 2'd3, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'hF, 1'b0); check_all("gi2", 16'hA321, 4'b0000, 1'b0, 2'd3, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd4, 1'b0); check_all("g3",  16'h4321, 4'b1000, 1'b1, 2'd0, 1'b1, 1'b0);

`ifdef DEMUX4_PARITY_EN
    // Bad parity mid-frame drops the word and returns to HUNT
    step(1'b1, 1'b1, 4'd1, 1'b0); check_all("p0",   16'h4321, 4'b0001, 1'b0, 2'd1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'b0111, 1'b1); check_all("pbad", 16'h4321, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'd5, 1'b1); check_all("psync", 16'h4321, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'd1, 1'b0); check_all("p1",   16'h4321, 4'b0001, 1'b0, 2'd1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'b0111, 1'b0); check_all("pgood", 16'h4371, 4'b0010, 1'b0, 2'd2, 1'b1, 1'b0);
`endif

    // Reset in the middle of a frame with a valid word present
    step(1'b1, 1'b1, 4'd5, 1'b0);
    check("rm.pre", 32'(locked), 32'd1);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; in_sync = 1'b0; in_data = 4'd6; in_par = ^in_data;
    @(posedge clk);
    #1;
    check_all("rstmid", 16'h0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
